freq_generator: RTL



---
 rtl/freq_gen_pkg.sv | 19 +
 rtl/udiv_seq.sv | 67 ++++++
 rtl/freq_generator.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/freq_gen_pkg.sv
// rtl/freq_gen_pkg.sv - shared defaults, FSM states and helpers for freq_generator
package freq_gen_pkg;

  localparam int CLK_HZ_DEFAULT = 100000000;
  localparam int FREQ_W_DEFAULT = 12;
  localparam int DIV_W          = 32;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    PEND
  } fg_state_e;

  // A zero quotient means the request is above CLK_HZ/2; run as fast as possible.
  function automatic logic [DIV_W-1:0] clamp_half(input logic [DIV_W-1:0] q);
    return (q == '0) ? DIV_W'(1) : q;
  endfunction

endpackage

// File: rtl/udiv_seq.sv
// rtl/udiv_seq.sv - restoring unsigned divider, one quotient bit per cycle
module udiv_seq #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 13
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  logic [DIVIDEND_W-1:0] r_quo;
  logic [DIVISOR_W-1:0]  r_rem;
  logic [DIVISOR_W-1:0]  r_div;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_done;

  logic [DIVISOR_W:0]    w_shift;
  logic [DIVISOR_W-1:0]  w_diff;
  logic                  w_ge;

  // Dividend bits shift out of r_quo as quotient bits shift in.
  assign w_shift = {r_rem, r_quo[DIVIDEND_W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift[DIVISOR_W-1:0] - r_div;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_quo  <= dividend;
        r_rem  <= '0;
        r_div  <= divisor;
        r_cnt  <= CNT_W'(DIVIDEND_W - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_ge ? w_diff : w_shift[DIVISOR_W-1:0];
        r_quo <= {r_quo[DIVIDEND_W-2:0], w_ge};
        if (r_cnt == '0) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign quotient = r_quo;

endmodule

// File: rtl/freq_generator.sv
// rtl/freq_generator.sv - programmable 50% square-wave source with glitch-free retune/stop
// Optional FREQ_GEN_EDGE_CNT_EN adds edge_cnt, a count of OUT rising edges since reset.
module freq_generator
  import freq_gen_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT,
  parameter int FREQ_W = FREQ_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [FREQ_W-1:0] freq_in,
  input  logic              freq_valid,
  output logic              freq_ready,
`ifdef FREQ_GEN_EDGE_CNT_EN
  output logic [31:0]       edge_cnt,
`endif
  output logic              OUT,
  output logic              active,
  output logic [FREQ_W-1:0] freq_cur
);

  fg_state_e         r_state;
  logic              r_ready;
  logic              r_out;
  logic              r_active;
  logic [FREQ_W-1:0] r_freq_cur;
  logic [FREQ_W-1:0] r_req_freq;
  logic [FREQ_W-1:0] r_pend_freq;
  logic              r_pend_stop;
  logic [DIV_W-1:0]  r_pend_half;
  logic [DIV_W-1:0]  r_half;
  logic [DIV_W-1:0]  r_phase;

  logic              w_accept;
  logic              w_toggle;
  logic              w_apply;
  logic              w_div_start;
  logic              w_div_busy;
  logic              w_div_done;
  logic [DIV_W-1:0]  w_quotient;

  assign freq_ready  = r_ready & ~w_div_busy;
  assign w_accept    = freq_valid & freq_ready;
  assign w_div_start = w_accept && (freq_in != '0);
  assign w_toggle    = r_active && (r_phase == r_half - DIV_W'(1));
  // A stop may cut a low phase short, but a high phase always runs to its toggle.
  assign w_apply     = (r_state == PEND) && !w_accept &&
                       (w_toggle || !r_active || (r_pend_stop && !r_out));

  udiv_seq #(
    .DIVIDEND_W(DIV_W),
    .DIVISOR_W (FREQ_W + 1)
  ) u_div (
    .CLK     (CLK),
    .RST     (RST),
    .start   (w_div_start),
    .dividend(DIV_W'(CLK_HZ)),
    .divisor ({freq_in, 1'b0}),
    .busy    (w_div_busy),
    .done    (w_div_done),
    .quotient(w_quotient)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_out       <= 1'b0;
      r_active    <= 1'b0;
      r_freq_cur  <= '0;
      r_req_freq  <= '0;
      r_pend_freq <= '0;
      r_pend_stop <= 1'b0;
      r_pend_half <= '0;
      r_half      <= '0;
      r_phase     <= '0;
    end else begin
      if (w_accept) begin
        r_req_freq <= freq_in;
        if (freq_in == '0) begin
          r_state     <= PEND;
          r_pend_stop <= 1'b1;
          r_pend_freq <= '0;
        end else begin
          r_state <= DIV;
          r_ready <= 1'b0;
        end
      end else begin
        case (r_state)
          DIV: if (w_div_done) begin
            r_pend_half <= clamp_half(w_quotient);
            r_pend_freq <= r_req_freq;
            r_pend_stop <= 1'b0;
            r_state     <= PEND;
            r_ready     <= 1'b1;
          end
          PEND: if (w_apply) r_state <= IDLE;
          IDLE: r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end

      if (w_apply && r_pend_stop) begin
        r_active   <= 1'b0;
        r_out      <= 1'b0;
        r_freq_cur <= '0;
        r_phase    <= '0;
      end else if (w_apply) begin
        r_half     <= r_pend_half;
        r_phase    <= '0;
        r_freq_cur <= r_pend_freq;
        r_active   <= 1'b1;
        if (w_toggle) r_out <= ~r_out;
      end else if (w_toggle) begin
        r_out   <= ~r_out;
        r_phase <= '0;
      end else if (r_active) begin
        r_phase <= r_phase + DIV_W'(1);
      end
    end
  end

`ifdef FREQ_GEN_EDGE_CNT_EN
  logic        r_out_prev;
  logic [31:0] r_edge_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_prev <= 1'b0;
      r_edge_cnt <= '0;
    end else begin
      r_out_prev <= r_out;
      if (r_out && !r_out_prev) r_edge_cnt <= r_edge_cnt + 32'd1;
    end
  end

  assign edge_cnt = r_edge_cnt;
`endif

  assign OUT      = r_out;
  assign active   = r_active;
  assign freq_cur = r_freq_cur;

endmodule
